// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM generator.
// All channels share one prescaler and one period counter. Each channel
// compares the counter against its own duty value and has its own polarity.
// Period, duty and mode are shadowed and reload only at period boundaries,
// so input changes never produce a partial or glitched pulse.
module pwm_multi #(
  parameter int CH    = 4,
  parameter int CNT_W = 16,
  parameter int DIV_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pwm_en,
  input  logic [DIV_W-1:0]      pwm_div,
  input  logic [CNT_W-1:0]      pwm_period,
  input  logic                  pwm_mode,
  input  logic [CH*CNT_W-1:0]   pwm_duty,
  input  logic [CH-1:0]         pwm_pol,
  output logic [CH-1:0]         pwm,
  output logic                  period_tick
);

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [DIV_W-1:0]            presc;
  logic [CNT_W-1:0]            cnt;
  dir_t                        dir;
  logic [CNT_W-1:0]            sh_period;
  logic [CH-1:0][CNT_W-1:0]    sh_duty;
  logic                        sh_mode;
  logic                        tick;
  logic                        boundary;
  logic [CH-1:0]               raw;

  assign tick = pwm_en && (presc == pwm_div);

  // Boundary: edge mode wraps at cnt == P; center mode ends on the
  // downward zero (or on every tick when the period is zero).
  always_comb begin
    boundary = 1'b0;
    if (tick) begin
      if (!sh_mode)
        boundary = (cnt == sh_period);
      else
        boundary = (sh_period == '0) || ((cnt == '0) && (dir == DIR_DOWN));
    end
  end

  // Raw channel level: counter below duty, forced low when disabled or
  // when a zero-length center-aligned period is selected.
  always_comb begin
    raw = '0;
    for (int i = 0; i < CH; i++) begin
      raw[i] = pwm_en && !(sh_mode && (sh_period == '0)) && (cnt < sh_duty[i]);
    end
  end

  // Prescaler: counts 0..pwm_div, producing one tick per pwm_div+1 clocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      presc <= '0;
    else if (!pwm_en || (presc == pwm_div))
      presc <= '0;
    else
      presc <= presc + DIV_W'(1);
  end

  // Period counter and direction; a boundary always restarts at 0 counting up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      dir <= DIR_UP;
    end else if (!pwm_en || boundary) begin
      cnt <= '0;
      dir <= DIR_UP;
    end else if (tick) begin
      if (!sh_mode) begin
        cnt <= cnt + CNT_ONE;
      end else if (dir == DIR_UP) begin
        if (cnt == sh_period - CNT_ONE)
          dir <= DIR_DOWN;
        else
          cnt <= cnt + CNT_ONE;
      end else begin
        cnt <= cnt - CNT_ONE;
      end
    end
  end

  // Shadow registers: track inputs while disabled, reload only at boundaries while enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_period <= '0;
      sh_duty   <= '0;
      sh_mode   <= 1'b0;
    end else if (!pwm_en || boundary) begin
      sh_period <= pwm_period;
      sh_duty   <= pwm_duty;
      sh_mode   <= pwm_mode;
    end
  end

  // Registered outputs: polarity applied directly, period tick follows the boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm         <= '0;
      period_tick <= 1'b0;
    end else begin
      pwm         <= raw ^ pwm_pol;
      period_tick <= boundary;
    end
  end

endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: self-checking bench for pwm_multi with a time-based reference model.
module tb_pwm_multi;

  localparam int CH    = 4;
  localparam int CNT_W = 16;
  localparam int DIV_W = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 pwm_en;
  logic [DIV_W-1:0]     pwm_div;
  logic [CNT_W-1:0]     pwm_period;
  logic                 pwm_mode;
  logic [CH*CNT_W-1:0]  pwm_duty;
  logic [CH-1:0]        pwm_pol;
  logic [CH-1:0]        pwm;
  logic                 period_tick;

  int total = 0;
  int bad   = 0;

  // Reference model state: clocks and ticks elapsed since enable / period start.
  int m_clk;
  int m_ticks;
  int sh_p;
  int sh_m;
  int sh_d[CH];
  logic [CH-1:0] exp_pwm;
  logic          exp_pt;

  int hi[CH];
  int ptc;

  pwm_multi #(.CH(CH), .CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .pwm_en      (pwm_en),
    .pwm_div     (pwm_div),
    .pwm_period  (pwm_period),
    .pwm_mode    (pwm_mode),
    .pwm_duty    (pwm_duty),
    .pwm_pol     (pwm_pol),
    .pwm         (pwm),
    .period_tick (period_tick)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic en, input int div, input int period, input logic mode,
                               input logic [CH*CNT_W-1:0] duty, input logic [CH-1:0] pol);
    pwm_en     = en;
    pwm_div    = DIV_W'(div);
    pwm_period = CNT_W'(period);
    pwm_mode   = mode;
    pwm_duty   = duty;
    pwm_pol    = pol;
  endtask

  task automatic loadShadow();
    sh_p = int'(pwm_period);
    sh_m = int'(pwm_mode);
    for (int i = 0; i < CH; i++) sh_d[i] = int'(pwm_duty[i*CNT_W +: CNT_W]);
  endtask

  task automatic resetModel();
    m_clk   = 0;
    m_ticks = 0;
    sh_p    = 0;
    sh_m    = 0;
    for (int i = 0; i < CH; i++) sh_d[i] = 0;
    exp_pwm = '0;
    exp_pt  = 1'b0;
  endtask

  // One clock of the model: position within the period gives the counter value.
  task automatic modelStep();
    int pos, cval, plen, div_i;
    logic tk;
    if (rst) begin
      resetModel();
      return;
    end
    if (!pwm_en) begin
      m_clk   = 0;
      m_ticks = 0;
      loadShadow();
      exp_pwm = pwm_pol;
      exp_pt  = 1'b0;
      return;
    end
    pos = m_ticks;
    if (sh_m == 0) cval = pos;
    else if (pos < sh_p) cval = pos;
    else cval = 2 * sh_p - 1 - pos;
    for (int i = 0; i < CH; i++) begin
      if (sh_m == 1 && sh_p == 0) exp_pwm[i] = pwm_pol[i];
      else exp_pwm[i] = (cval < sh_d[i]) ^ pwm_pol[i];
    end
    div_i = int'(pwm_div);
    tk = ((m_clk % (div_i + 1)) == div_i);
    m_clk++;
    if (sh_m == 0) plen = sh_p + 1;
    else if (sh_p == 0) plen = 1;
    else plen = 2 * sh_p;
    exp_pt = 1'b0;
    if (tk) begin
      if (m_ticks == plen - 1) begin
        m_ticks = 0;
        loadShadow();
        exp_pt = 1'b1;
      end else begin
        m_ticks++;
      end
    end
  endtask

  task automatic stepClock();
    @(posedge clk);
    modelStep();
    #1;
    checkOutput("pwm", 32'(pwm), 32'(exp_pwm));
    checkOutput("period_tick", 32'(period_tick), 32'(exp_pt));
    for (int i = 0; i < CH; i++) hi[i] += int'(pwm[i]);
    ptc += int'(period_tick);
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) stepClock();
  endtask

  task automatic clearCounts();
    for (int i = 0; i < CH; i++) hi[i] = 0;
    ptc = 0;
  endtask

  function automatic logic [CH*CNT_W-1:0] packDuty(input int d0, input int d1, input int d2, input int d3);
    return {CNT_W'(d3), CNT_W'(d2), CNT_W'(d1), CNT_W'(d0)};
  endfunction

  // Directed plan followed by randomized segments, all checked every clock.
  initial begin
    int div, per, n, found;
    logic mode;
    logic [CH-1:0] pol;
    logic [CH*CNT_W-1:0] duty;

    rst = 1'b1;
    applyStimulus(1'b0, 0, 0, 1'b0, '0, '0);
    resetModel();
    clearCounts();
    #2;
    checkOutput("reset_pwm", 32'(pwm), 32'h0);
    checkOutput("reset_tick", 32'(period_tick), 32'h0);
    steps(2);
    rst = 1'b0;

    // Edge-aligned basic operation.
    applyStimulus(1'b0, 0, 9, 1'b0, packDuty(3, 0, 10, 5), 4'b0000);
    steps(2);
    applyStimulus(1'b1, 0, 9, 1'b0, packDuty(3, 0, 10, 5), 4'b0000);
    steps(20);
    clearCounts();
    steps(10);
    checkOutput("edge_hi0", hi[0], 3);
    checkOutput("edge_hi1", hi[1], 0);
    checkOutput("edge_hi2", hi[2], 10);
    checkOutput("edge_hi3", hi[3], 5);
    checkOutput("edge_ticks", ptc, 1);

    // Shadowed duty change mid-period.
    steps(5);
    applyStimulus(1'b1, 0, 9, 1'b0, packDuty(7, 0, 10, 5), 4'b0000);
    steps(15);
    clearCounts();
    steps(10);
    checkOutput("shadow_hi0", hi[0], 7);

    // Prescaler divide by two.
    applyStimulus(1'b0, 1, 9, 1'b0, packDuty(3, 0, 10, 5), 4'b0000);
    steps(2);
    applyStimulus(1'b1, 1, 9, 1'b0, packDuty(3, 0, 10, 5), 4'b0000);
    steps(40);
    clearCounts();
    steps(20);
    checkOutput("presc_hi0", hi[0], 6);
    checkOutput("presc_ticks", ptc, 1);

    // Center-aligned mode.
    applyStimulus(1'b0, 0, 4, 1'b1, packDuty(2, 1, 4, 0), 4'b0000);
    steps(2);
    applyStimulus(1'b1, 0, 4, 1'b1, packDuty(2, 1, 4, 0), 4'b0000);
    steps(16);
    clearCounts();
    steps(8);
    checkOutput("center_hi0", hi[0], 4);
    checkOutput("center_ticks", ptc, 1);
    applyStimulus(1'b1, 0, 4, 1'b1, packDuty(4, 1, 4, 0), 4'b0000);
    steps(16);
    clearCounts();
    steps(8);
    checkOutput("center_full_hi0", hi[0], 8);

    // Polarity, disable, re-enable.
    applyStimulus(1'b1, 0, 4, 1'b1, packDuty(2, 1, 4, 0), 4'b0101);
    steps(16);
    applyStimulus(1'b0, 0, 9, 1'b0, packDuty(3, 0, 10, 5), 4'b0101);
    stepClock();
    checkOutput("disable_pwm", 32'(pwm), 32'h5);
    applyStimulus(1'b1, 0, 9, 1'b0, packDuty(3, 0, 10, 5), 4'b0101);
    steps(25);

    // Mode change while enabled takes effect at the boundary.
    steps(3);
    applyStimulus(1'b1, 0, 5, 1'b1, packDuty(3, 2, 6, 1), 4'b0000);
    steps(30);

    // Asynchronous reset while the output is high.
    applyStimulus(1'b1, 0, 9, 1'b0, packDuty(9, 9, 9, 9), 4'b0000);
    steps(12);
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      if (exp_pwm[0]) found = 1;
      else stepClock();
    end
    checkOutput("wait_high", found, 1);
    #2;
    rst = 1'b1;
    resetModel();
    #1;
    checkOutput("async_rst_pwm", 32'(pwm), 32'h0);
    checkOutput("async_rst_tick", 32'(period_tick), 32'h0);
    @(negedge clk);
    steps(2);
    rst = 1'b0;
    applyStimulus(1'b1, 0, 9, 1'b0, packDuty(3, 0, 10, 5), 4'b0000);
    steps(25);

    // Full-width period.
    applyStimulus(1'b0, 0, 65535, 1'b0, packDuty(65535, 0, 1, 40000), 4'b0010);
    steps(2);
    applyStimulus(1'b1, 0, 65535, 1'b0, packDuty(65535, 0, 1, 40000), 4'b0010);
    steps(40);

    // Randomized segments.
    for (int seg = 0; seg < 30; seg++) begin
      div  = $urandom_range(0, 3);
      per  = $urandom_range(0, 12);
      mode = 1'($urandom_range(0, 1));
      pol  = 4'($urandom_range(0, 15));
      for (int i = 0; i < CH; i++) duty[i*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, per + 2));
      applyStimulus(1'b0, div, per, mode, duty, pol);
      steps(2);
      applyStimulus(1'b1, div, per, mode, duty, pol);
      n = $urandom_range(40, 80);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 15) == 0) begin
          per  = $urandom_range(0, 12);
          mode = 1'($urandom_range(0, 1));
          pol  = 4'($urandom_range(0, 15));
          for (int i = 0; i < CH; i++) duty[i*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, per + 2));
        end
        applyStimulus(($urandom_range(0, 39) != 0), div, per, mode, duty, pol);
        if ($urandom_range(0, 99) == 0) rst = 1'b1;
        stepClock();
        rst = 1'b0;
      end
    end

    // Maximum prescaler: one boundary after 65536 clocks.
    applyStimulus(1'b0, 16'hFFFF, 0, 1'b0, packDuty(1, 0, 1, 0), 4'b0000);
    steps(2);
    applyStimulus(1'b1, 16'hFFFF, 0, 1'b0, packDuty(1, 0, 1, 0), 4'b0000);
    clearCounts();
    steps(65530);
    checkOutput("maxdiv_early", ptc, 0);
    steps(10);
    checkOutput("maxdiv_ticks", ptc, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
- Multi-channel, parametrised PWM generator; the successor to the single-channel percent-duty PWM.
- CH channels share one prescaler and one period counter. Each channel has its own duty (absolute counts, not percent) and its own output polarity.
- Adds a center-aligned mode, glitch-free shadow-register updates at period boundaries, and a period tick for software/DMA sync.
- Sits between the register block and the pads / motor driver.

Parameters:
- CH, 4, number of PWM channels (≥1).
- CNT_W, 16, width of period and duty values.
- DIV_W, 16, width of prescaler divide value.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- pwm_en  in  1  global enable; low = outputs idle, counters cleared.
- pwm_div  in  DIV_W  prescaler; counter advances once every pwm_div+1 clk.
- pwm_period  in  CNT_W  period value P.
- pwm_mode  in  1  0 = edge-aligned, 1 = center-aligned.
- pwm_duty  in  CH*CNT_W  per-channel duty D; channel i = bits [i*CNT_W +: CNT_W].
- pwm_pol  in  CH  per-channel polarity; 1 inverts the output.
- pwm  out  CH  PWM outputs (registered).
- period_tick  out  1  one-clk pulse at each period boundary.

Interface (already decided): one clock; reset is asynchronous and active-high.

Behaviour:
- Reset (async, any time, including mid-period): prescaler, cnt, dir, pwm and period_tick all go to 0; the shadow registers load 0. Operation restarts cleanly after reset release.
- Prescaler: counts 0..pwm_div. tick = (presc == pwm_div). pwm_div = 0 gives a tick every clk. Reaching the terminal value clears presc on the next clk.
- Shadow registers: hold P, D[CH], mode.
  - While pwm_en = 0: loaded every clk.
  - While pwm_en = 1: loaded only on a boundary tick.
  - pwm_pol is NOT shadowed; it applies on the next clk.
- pwm_en = 0:
  - presc, cnt and dir are held at 0; period_tick = 0.
  - Raw channel output is 0, so pwm = pwm_pol (registered, 1 clk latency).
- Edge mode, counting on tick only:
  - cnt runs 0,1,..,P, then wraps to 0. Period = P+1 ticks.
  - Boundary = the tick where cnt = P (wrap).
  - raw_i = (cnt < D_i).
  - D_i = 0 gives constant low; D_i ≥ P+1 gives constant high.
- Center mode, counting on tick only:
  - Up phase: cnt 0..P-1. At P-1 with dir = up, set dir = down and hold cnt.
  - Down phase: P-1..0. At 0 with dir = down, set dir = up and hold cnt.
  - Every value appears twice; period = 2P ticks.
  - Boundary = the tick where cnt = 0 and dir = down.
  - raw_i = (cnt < D_i), giving a high time of 2·D_i ticks centred on the counter-zero hold.
  - D_i ≥ P gives constant high. P = 0 holds cnt = 0, raw = 0, and every tick is a boundary.
- Mode change while enabled: takes effect only at a boundary, through the shadow register. At that boundary cnt restarts at 0 with dir = up.
- Output timing: pwm_i <= raw_i XOR pwm_pol_i, registered. pwm in clk n+1 reflects cnt and shadow values in clk n.
- period_tick: asserted in the clk after the boundary tick, aligned with the reload of the shadow registers. Width is exactly 1 clk regardless of pwm_div.
- Input changes between boundaries never produce a partial or glitched pulse.
- Width rules:
  - Comparisons are unsigned, CNT_W wide.
  - P = 2^CNT_W−1 is legal in edge mode; no overflow, since cnt ≤ P.

Test Plan:
- Edge basic. Enable with div=0, P=9, D0=3, D1=0, D2=10, D3=5, pol=0.
  - Period = 10 clk.
  - pwm[0] high 3 / low 7; pwm[1] always 0; pwm[2] always 1; pwm[3] high 5.
  - period_tick every 10 clk.
- Prescaler. div=1, P=9, D0=3 → period 20 clk, high 6 clk. div=0xFFFF is spot-checked for correct tick spacing.
- Shadow update. Mid-period, write D0 from 3 to 7 → the current period still shows 3 high; the next period shows 7. No runt pulse.
- Center mode. mode=1, div=0, P=4, D0=2 → period 8 clk, pwm[0] high 4 consecutive clk, period_tick every 8 clk. Setting D0=4 gives constant high.
- Polarity and disable.
  - pol=4'b0101 inverts ch0 and ch2.
  - Dropping pwm_en gives pwm=4'b0101 after 1 clk.
  - Re-enabling restarts from cnt=0 using the current inputs.
- Async reset mid-period. Assert rst between clk edges → pwm=0 and period_tick=0 immediately. After release with pwm_en=1, the first full period is correct.
